// File: rtl/divisor_secuencial.sv
// divisor_secuencial: multi-cycle restoring integer divider for RV32M
// DIV/DIVU/REM/REMU. One quotient bit per cycle by trial subtraction.
// Sequence: REPOSO -> CALCULO (N cycles) -> AJUSTE -> FIN -> REPOSO.
// Optional build macro DIVISOR_ATAJO_EN: divide-by-zero and signed overflow
// are resolved at accept and go straight to FIN (1-cycle latency). Without
// it they take the full path and AJUSTE forces the special results.
module divisor_secuencial #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Inicio,
    input  logic         ConSigno,
    input  logic [N-1:0] Dividendo,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Cociente,
    output logic [N-1:0] Residuo,
    output logic         Listo,
    output logic         Ocupado
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        AJUSTE  = 2'd2,
        FIN     = 2'd3
    } estado_t;

    estado_t estado, estado_sig;

    logic [CW-1:0] contador;
    logic [N-1:0]  resto;         // partial remainder R
    logic [N-1:0]  cociente_par;  // dividend bits shift out, quotient bits shift in
    logic [N-1:0]  divisor_abs;
    logic          signo_c;
    logic          signo_r;
    logic          es_div0;
    logic          es_ovf;

    logic          div0_ent;
    logic          ovf_ent;
    logic [N:0]    r_desp;
    logic [N+1:0]  prueba;
    logic          acarreo;
    logic          bit_alto_unused;

    // Two's-complement x when neg is set; used for both |x| and sign fix-up.
    function automatic logic [N-1:0] complemento(input logic [N-1:0] x,
                                                 input logic         neg);
        logic signed [N-1:0] xs;
        xs = signed'(x);
        return neg ? unsigned'(-xs) : x;
    endfunction

    assign div0_ent = (Divisor == '0);
    assign ovf_ent  = ConSigno && (Dividendo == MIN_NEG) && (Divisor == '1);

    // Trial subtraction R - D as R + ~D + 1 on N+1 bits; carry-out = no borrow.
    // A successful difference is always below D, so bit N of it is always 0.
    assign r_desp          = {resto, cociente_par[N-1]};
    assign prueba          = {1'b0, r_desp} + {1'b0, ~{1'b0, divisor_abs}}
                             + {{(N+1){1'b0}}, 1'b1};
    assign acarreo         = prueba[N+1];
    assign bit_alto_unused = prueba[N];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        estado_sig = estado;
        Listo      = 1'b0;
        Ocupado    = 1'b1;
        case (estado)
            REPOSO: begin
                Ocupado = 1'b0;
                if (Inicio) begin
`ifdef DIVISOR_ATAJO_EN
                    estado_sig = (div0_ent || ovf_ent) ? FIN : CALCULO;
`else
                    estado_sig = CALCULO;
`endif
                end
            end
            CALCULO: begin
                if (contador == '0) begin
                    estado_sig = AJUSTE;
                end
            end
            AJUSTE: begin
                estado_sig = FIN;
            end
            FIN: begin
                Listo      = 1'b1;
                estado_sig = REPOSO;
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contador     <= '0;
            resto        <= '0;
            cociente_par <= '0;
            divisor_abs  <= '0;
            signo_c      <= 1'b0;
            signo_r      <= 1'b0;
            es_div0      <= 1'b0;
            es_ovf       <= 1'b0;
            Cociente     <= '0;
            Residuo      <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (Inicio) begin
                        resto        <= '0;
                        cociente_par <= complemento(Dividendo, ConSigno & Dividendo[N-1]);
                        divisor_abs  <= complemento(Divisor, ConSigno & Divisor[N-1]);
                        signo_c      <= ConSigno & (Dividendo[N-1] ^ Divisor[N-1]);
                        signo_r      <= ConSigno & Dividendo[N-1];
                        es_div0      <= div0_ent;
                        es_ovf       <= ovf_ent;
                        contador     <= CW'(N - 1);
`ifdef DIVISOR_ATAJO_EN
                        if (div0_ent) begin
                            Cociente <= '1;
                            Residuo  <= Dividendo;
                        end else if (ovf_ent) begin
                            Cociente <= MIN_NEG;
                            Residuo  <= '0;
                        end
`endif
                    end
                end
                CALCULO: begin
                    resto        <= acarreo ? prueba[N-1:0] : r_desp[N-1:0];
                    cociente_par <= {cociente_par[N-2:0], acarreo};
                    contador     <= contador - CW'(1);
                end
                AJUSTE: begin
                    // With D = 0 the remainder path carries |Dividendo| through
                    // unchanged, so the sign fix-up restores Dividendo itself.
                    if (es_div0) begin
                        Cociente <= '1;
                        Residuo  <= complemento(resto, signo_r);
                    end else if (es_ovf) begin
                        Cociente <= MIN_NEG;
                        Residuo  <= '0;
                    end else begin
                        Cociente <= complemento(cociente_par, signo_c);
                        Residuo  <= complemento(resto, signo_r);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Testbench for divisor_secuencial (N = 32). Directed operations plus a
// cycle-level reference model of the handshake and results.
module tb_divisor_secuencial;

    localparam int N   = 32;
    localparam int LAT = N + 2;
`ifdef DIVISOR_ATAJO_EN
    localparam bit ATAJO = 1'b1;
`else
    localparam bit ATAJO = 1'b0;
`endif
    localparam int LAT_ESP = ATAJO ? 1 : LAT;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Inicio = 1'b0;
    logic         ConSigno = 1'b0;
    logic [N-1:0] Dividendo = '0;
    logic [N-1:0] Divisor = '0;
    logic [N-1:0] Cociente;
    logic [N-1:0] Residuo;
    logic         Listo;
    logic         Ocupado;

    int n_asrt = 0;
    int n_fail = 0;
    int listo_pulsos = 0;
    bit chk_en = 1'b0;

    divisor_secuencial #(.N(N)) dut (
        .clk(clk), .rst(rst), .Inicio(Inicio), .ConSigno(ConSigno),
        .Dividendo(Dividendo), .Divisor(Divisor), .Cociente(Cociente),
        .Residuo(Residuo), .Listo(Listo), .Ocupado(Ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nombre, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nombre, act, exp);
        end
    endtask

    // RISC-V division semantics from plain arithmetic.
    function automatic void modelo(input logic [N-1:0] a, input logic [N-1:0] b, input bit s,
                                   output logic [N-1:0] q, output logic [N-1:0] r, output bit esp);
        longint sa, sb;
        esp = 1'b0;
        if (b == '0) begin
            q = '1; r = a; esp = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == '1) begin
            q = 32'h8000_0000; r = '0; esp = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = N'(sa / sb);
            r  = N'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Reference timeline: m_k is the cycle index since accept (0 = idle).
    int           m_k = 0;
    int           m_lat = LAT;
    logic [N-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

    always @(posedge clk or posedge rst) begin : ref_model
        logic [N-1:0] q, r;
        bit esp;
        if (rst) begin
            m_k <= 0;
            m_q <= '0;
            m_r <= '0;
        end else if (m_k != 0) begin
            if (m_k == m_lat) begin
                m_k <= 0;
            end else begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_lat) begin
                    m_q <= p_q;
                    m_r <= p_r;
                end
            end
        end else if (Inicio) begin
            modelo(Dividendo, Divisor, ConSigno, q, r, esp);
            p_q   <= q;
            p_r   <= r;
            m_lat <= (esp && ATAJO) ? 1 : LAT;
            m_k   <= 1;
            if (esp && ATAJO) begin
                m_q <= q;
                m_r <= r;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("Ocupado", N'(Ocupado), N'(m_k != 0));
            chk("Listo", N'(Listo), N'(m_k != 0 && m_k == m_lat));
            chk("Cociente", Cociente, m_q);
            chk("Residuo", Residuo, m_r);
            if (Listo === 1'b1) listo_pulsos++;
        end
    end

    task automatic lanzar(input logic [N-1:0] a, input logic [N-1:0] b, input bit s);
        @(negedge clk);
        Dividendo = a;
        Divisor   = b;
        ConSigno  = s;
        Inicio    = 1'b1;
        @(negedge clk);
        Inicio    = 1'b0;
    endtask

    task automatic esperar_listo(input string nombre, input logic [N-1:0] eq, input logic [N-1:0] er,
                                 input int lat, input int k0);
        int k;
        bit visto;
        k = k0;
        visto = 1'b0;
        while (!visto && k <= 100) begin
            if (Listo === 1'b1) visto = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk({nombre, ".latencia"}, N'(k), N'(lat));
        if (visto) begin
            chk({nombre, ".cociente"}, Cociente, eq);
            chk({nombre, ".residuo"}, Residuo, er);
        end
        @(negedge clk);
    endtask

    task automatic operar(input string nombre, input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit s, input logic [N-1:0] eq, input logic [N-1:0] er, input int lat);
        lanzar(a, b, s);
        esperar_listo(nombre, eq, er, lat, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : estimulo
        logic [N-1:0] q, r;
        bit esp;
        int pulsos0;

        repeat (3) @(negedge clk);
        chk("reset.Ocupado", N'(Ocupado), '0);
        chk("reset.Listo", N'(Listo), '0);
        chk("reset.Cociente", Cociente, '0);
        chk("reset.Residuo", Residuo, '0);
        rst    = 1'b0;
        chk_en = 1'b1;

        modelo(32'd100, 32'd7, 1'b0, q, r, esp);
        chk("modelo.u100/7.q", q, 32'd14);
        chk("modelo.u100/7.r", r, 32'd2);
        modelo(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, esp);
        chk("modelo.s-7/2.q", q, 32'hFFFF_FFFD);
        chk("modelo.s-7/2.r", r, 32'hFFFF_FFFF);

        operar("u100/7",   32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         LAT);
        operar("s-7/2",    32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
        operar("s7/-2",    32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         LAT);
        operar("s-100/7",  32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, LAT);
        operar("u3/7",     32'd3,         32'd7,         1'b0, 32'd0,         32'd3,         LAT);
        operar("u5/0",     32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         LAT_ESP);
        operar("s5/0",     32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'd5,         LAT_ESP);
        operar("s-5/0",    32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT_ESP);
        operar("s.ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         LAT_ESP);
        operar("u.ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, LAT);

        // Inicio while busy must be ignored
        pulsos0 = listo_pulsos;
        lanzar(32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        Dividendo = 32'h1234;
        Divisor   = 32'd0;
        ConSigno  = 1'b1;
        Inicio    = 1'b1;
        @(negedge clk);
        Inicio    = 1'b0;
        esperar_listo("ocupado.ignora", 32'd14, 32'd2, LAT, 5);
        repeat (5) @(negedge clk);
        chk("ocupado.pulsos", N'(listo_pulsos - pulsos0), 32'd1);

        // Asynchronous reset in the middle of an operation
        lanzar(32'hFFFF_FFFF, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.Ocupado", N'(Ocupado), '0);
        chk("abort.Listo", N'(Listo), '0);
        chk("abort.Cociente", Cociente, '0);
        chk("abort.Residuo", Residuo, '0);
        @(negedge clk);
        rst = 1'b0;
        pulsos0 = listo_pulsos;
        repeat (40) @(negedge clk);
        chk("abort.sin_listo", N'(listo_pulsos - pulsos0), 32'd0);
        operar("tras_abort", 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, LAT);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
